// File: rtl/adder_multiword_seq.sv
// Wide adder sequencer: drives one external 16-bit adder one chunk per cycle, LSB chunk first.
// Latency: operands accepted at edge T, out_valid high after edge T+WORDS; issue interval WORDS+2.
// Backpressure: in_ready only in IDLE; result held in DONE until out_valid && out_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (op_a, op_b, op_cin)
//   out_valid/out_ready   result handshake (result, result_cout[, result_ovf])
//   add_a/add_b/add_cin   drive the external combinational adder
//   add_sum/add_cout      sampled from the adder in the same cycle
// Optional: define ADDER_SEQ_OVF_EN to add result_ovf, the signed overflow of the full add.

module adder_multiword_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   op_a,
    input  logic [16*WORDS-1:0]   op_b,
    input  logic                  op_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   result,
    output logic                  result_cout,
`ifdef ADDER_SEQ_OVF_EN
    output logic                  result_ovf,
`endif
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    output logic                  add_cin,
    input  logic [15:0]           add_sum,
    input  logic                  add_cout
);

    localparam int W    = 16 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            cout_q, cout_d;
    logic            out_valid_q, out_valid_d;
`ifdef ADDER_SEQ_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
`ifdef ADDER_SEQ_OVF_EN
        ovf_d       = ovf_q;
`endif
        add_a       = 16'd0;
        add_b       = 16'd0;
        add_cin     = 1'b0;

        case (state_q)
            IDLE: begin
                // in_ready is high in IDLE, so in_valid alone completes the handshake.
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = op_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Explicit chunk mux keeps the index arithmetic width-clean for any WORDS.
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        add_a               = a_q[i*16 +: 16];
                        add_b               = b_q[i*16 +: 16];
                        res_d[i*16 +: 16]   = add_sum;
                    end
                end
                add_cin = carry_q;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    // Index parks on the last chunk; it is reloaded on the next accept.
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    cout_d      = add_cout;
`ifdef ADDER_SEQ_OVF_EN
                    // a^b^sum at bit 15 recovers the carry into the MSB; XOR with carry out.
                    ovf_d       = add_a[15] ^ add_b[15] ^ add_sum[15] ^ add_cout;
`endif
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign result      = res_q;
    assign result_cout = cout_q;
`ifdef ADDER_SEQ_OVF_EN
    assign result_ovf  = ovf_q;
`endif

endmodule
